// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding and decode helpers for the ALU issue sequencer.
package alu_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_MUL = 4'b0001;
    localparam logic [3:0] OP_DIV = 4'b0010;
    localparam logic [3:0] OP_ROL = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;
    localparam logic [3:0] OP_SLL = 4'b1010;
    localparam logic [3:0] OP_SLR = 4'b1011;
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_AND = 4'b1101;
    localparam logic [3:0] OP_SUB = 4'b1110;
    localparam logic [3:0] OP_ADD = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // True for every control code the ALU implements.
    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL,
            OP_DIV, OP_SLL, OP_SLR, OP_ROL, OP_ROR: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // Number of cycles the ALU inputs must be held before its outputs are trusted.
    function automatic logic [7:0] op_latency(input logic [3:0] op, input int mul_lat,
                                              input int div_lat, input int base_lat);
        case (op)
            OP_MUL:  return 8'(mul_lat);
            OP_DIV:  return 8'(div_lat);
            default: return 8'(base_lat);
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_seq.sv
// Issue sequencer for the combinational 16-bit ALU: accepts one op, holds the
// ALU inputs for the op's settle time, captures result/flags, and hands them
// out over a valid/ready interface. Illegal ops and divide-by-zero bypass the ALU.
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 4,
    parameter int BASE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_crtl,
    input  logic [15:0] alu_r,
    input  logic        alu_o,
    input  logic        alu_n,
    input  logic        alu_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_r,
    output logic        out_o,
    output logic        out_n,
    output logic        out_z,
    output logic        out_err,
    output logic        busy
);

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic [3:0]  op_q;
    logic        start_ok;
    logic        accept;
    logic        cap;

    // The ALU's own N/Z are undefined for several ops, so flags are always
    // derived from R here instead.
    logic unused_alu_flags;
    assign unused_alu_flags = alu_n ^ alu_z;

    assign start_ok  = op_legal(in_op) && !(in_op == OP_DIV && in_b == 16'd0);
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode plus accept/capture strobes for the datapath.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        cap      = 1'b0;
        case (state)
            S_IDLE: if (in_valid) begin
                accept   = 1'b1;
                state_nx = start_ok ? S_EXEC : S_DONE;
            end
            S_EXEC: if (cnt == 8'd0) begin
                cap      = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand drive, settle counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_NOP;
            cnt      <= 8'd0;
            alu_a    <= 16'd0;
            alu_b    <= 16'd0;
            alu_crtl <= OP_NOP;
            out_r    <= 16'd0;
            out_o    <= 1'b0;
            out_n    <= 1'b0;
            out_z    <= 1'b0;
            out_err  <= 1'b0;
        end else if (accept) begin
            op_q <= in_op;
            if (start_ok) begin
                alu_a    <= in_a;
                alu_b    <= in_b;
                alu_crtl <= in_op;
                cnt      <= op_latency(in_op, MUL_LAT, DIV_LAT, BASE_LAT) - 8'd1;
            end else begin
                // Rejected ops never reach the ALU; its inputs stay idle.
                out_r   <= 16'hFFFF;
                out_o   <= 1'b0;
                out_n   <= 1'b0;
                out_z   <= 1'b0;
                out_err <= 1'b1;
            end
        end else if (state == S_EXEC) begin
            cnt <= cnt - 8'd1;
            if (cap) begin
                out_r    <= alu_r;
                out_o    <= (op_q == OP_ADD || op_q == OP_SUB) ? alu_o : 1'b0;
                out_n    <= alu_r[15];
                out_z    <= (alu_r == 16'd0);
                out_err  <= 1'b0;
                alu_a    <= 16'd0;
                alu_b    <= 16'd0;
                alu_crtl <= OP_NOP;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed self-checking bench for alu_issue_seq, with a behavioural ALU
// whose N/Z (and O for non-arithmetic ops) are deliberately junk.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a, in_b;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_crtl;
    logic [15:0] alu_r;
    logic        alu_o, alu_n, alu_z;
    logic        out_valid, out_ready;
    logic [15:0] out_r;
    logic        out_o, out_n, out_z, out_err;
    logic        busy;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    alu_issue_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_crtl(alu_crtl),
        .alu_r(alu_r), .alu_o(alu_o), .alu_n(alu_n), .alu_z(alu_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
        .out_o(out_o), .out_n(out_n), .out_z(out_z), .out_err(out_err), .busy(busy)
    );

    // Behavioural ALU; flags the sequencer must not trust are driven wrong on purpose.
    always_comb begin
        alu_r = 16'hDEAD;
        alu_o = 1'b1;
        case (alu_crtl)
            4'b1111: begin
                alu_r = alu_a + alu_b;
                alu_o = (alu_a[15] == alu_b[15]) && (alu_r[15] != alu_a[15]);
            end
            4'b1110: begin
                alu_r = alu_a - alu_b;
                alu_o = (alu_a[15] != alu_b[15]) && (alu_r[15] != alu_a[15]);
            end
            4'b1101: alu_r = alu_a & alu_b;
            4'b1100: alu_r = alu_a | alu_b;
            4'b0001: alu_r = alu_a * alu_b;
            4'b0010: alu_r = (alu_b != 16'd0) ? alu_a / alu_b : 16'hFFFF;
            4'b1010: alu_r = alu_a << alu_b[3:0];
            4'b1011: alu_r = alu_a >> alu_b[3:0];
            default: alu_r = 16'hDEAD;
        endcase
        alu_n = ~alu_r[15];
        alu_z = 1'b0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Offer one op for exactly one edge (the sequencer must be idle).
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_a = 16'd0; in_b = 16'd0; out_ready = 1'b1;
        step(); step();
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_out_r", out_r, 16'd0);
        chk("rst_flags", {12'd0, out_o, out_n, out_z, out_err}, 16'd0);
        chk("rst_crtl", 16'(alu_crtl), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        step();

        // add overflow
        issue(4'b1111, 16'h7FFF, 16'h0001);
        chk("add_crtl", 16'(alu_crtl), 16'hF);
        chk("add_in_ready", 16'(in_ready), 16'd0);
        chk("add_vld_early", 16'(out_valid), 16'd0);
        step();
        chk("add_vld", 16'(out_valid), 16'd1);
        chk("add_r", out_r, 16'h8000);
        chk("add_onze", {12'd0, out_o, out_n, out_z, out_err}, 16'b1100);
        chk("add_crtl_idle", 16'(alu_crtl), 16'd0);
        step();
        chk("add_hs_idle", 16'(in_ready), 16'd1);
        chk("add_r_persist", out_r, 16'h8000);

        // sub to zero
        issue(4'b1110, 16'h0005, 16'h0005);
        step();
        chk("sub_vld", 16'(out_valid), 16'd1);
        chk("sub_r", out_r, 16'h0000);
        chk("sub_onze", {12'd0, out_o, out_n, out_z, out_err}, 16'b0010);
        step();

        // mul, two settle cycles
        issue(4'b0001, 16'd3, 16'd4);
        chk("mul_crtl1", 16'(alu_crtl), 16'h1);
        step();
        chk("mul_crtl2", 16'(alu_crtl), 16'h1);
        chk("mul_vld_early", 16'(out_valid), 16'd0);
        step();
        chk("mul_vld", 16'(out_valid), 16'd1);
        chk("mul_r", out_r, 16'd12);
        chk("mul_onze", {12'd0, out_o, out_n, out_z, out_err}, 16'b0000);
        step();

        // divide-by-zero
        issue(4'b0010, 16'd9, 16'd0);
        chk("dz_vld", 16'(out_valid), 16'd1);
        chk("dz_r", out_r, 16'hFFFF);
        chk("dz_onze", {12'd0, out_o, out_n, out_z, out_err}, 16'b0001);
        chk("dz_crtl", 16'(alu_crtl), 16'd0);
        step();

        // illegal opcode
        issue(4'b0111, 16'd1, 16'd2);
        chk("ill_vld", 16'(out_valid), 16'd1);
        chk("ill_r", out_r, 16'hFFFF);
        chk("ill_onze", {12'd0, out_o, out_n, out_z, out_err}, 16'b0001);
        chk("ill_crtl", 16'(alu_crtl), 16'd0);
        step();

        // div 100/7, four settle cycles
        issue(4'b0010, 16'd100, 16'd7);
        step(); step(); step();
        chk("div_vld_early", 16'(out_valid), 16'd0);
        step();
        chk("div_vld", 16'(out_valid), 16'd1);
        chk("div_r", out_r, 16'd14);
        step();

        // backpressure: and, then hold out_ready low with a competing request
        out_ready = 1'b0;
        issue(4'b1101, 16'hF0F0, 16'h0FF0);
        step();
        chk("and_r", out_r, 16'h00F0);
        in_valid = 1'b1; in_op = 4'b1111; in_a = 16'd1; in_b = 16'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_vld", 16'(out_valid), 16'd1);
            chk("bp_r", out_r, 16'h00F0);
            chk("bp_in_ready", 16'(in_ready), 16'd0);
            chk("bp_crtl", 16'(alu_crtl), 16'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_hs_idle", 16'(in_ready), 16'd1);
        chk("bp_hs_vld", 16'(out_valid), 16'd0);
        step();
        in_valid = 1'b0;
        chk("bp_next_crtl", 16'(alu_crtl), 16'hF);
        step();
        chk("bp_next_r", out_r, 16'd2);
        step();

        // reset during the second EXEC cycle of a div
        issue(4'b0010, 16'd100, 16'd7);
        step();
        chk("mid_busy", 16'(busy), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_in_ready", 16'(in_ready), 16'd1);
        chk("mid_vld", 16'(out_valid), 16'd0);
        chk("mid_crtl", 16'(alu_crtl), 16'd0);
        chk("mid_busy_clr", 16'(busy), 16'd0);
        issue(4'b1111, 16'd1, 16'd1);
        step();
        chk("post_vld", 16'(out_valid), 16'd1);
        chk("post_r", out_r, 16'd2);
        step();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
